// File: rtl/stream_switcher_pkg.sv
// Shared definitions for the stream switcher: beat payload shape, switch FSM
// states and the selector-width helper.
`ifndef STREAM_SWITCHER_PKG_SV
`define STREAM_SWITCHER_PKG_SV

// Payload carried through each register slice: last flag above the data word.
`define STREAM_SWITCHER_BEAT_T(DW) struct packed { logic last; logic [(DW)-1:0] data; }

package stream_switcher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        SWITCH
    } sw_state_t;

    function automatic int sel_width(input int nch);
        return (nch > 1) ? $clog2(nch) : 1;
    endfunction

endpackage

`endif

// File: rtl/stream_reg_slice.sv
// One-entry valid/ready register slice: one cycle of latency, full throughput
// because a full entry can be replaced on the same edge it drains.
module stream_reg_slice #(
    parameter int DATA_W = 17
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
);

    logic              vld_p0;
    logic [DATA_W-1:0] data_p0;

    assign s_ready = !vld_p0 || m_ready;

    // stage p0: the single holding register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            data_p0 <= '0;
        end else if (s_ready) begin
            vld_p0 <= s_valid;
            if (s_valid) data_p0 <= s_data;
        end
    end

    assign m_valid = vld_p0;
    assign m_data  = data_p0;

endmodule

// File: rtl/stream_switcher.sv
// Registered channel switcher: routes one upstream port to one of NCH channel
// ports in both directions, changing channel only between packets once drained.
module stream_switcher
    import stream_switcher_pkg::*;
#(
    parameter  int NCH  = 8,
    parameter  int W    = 16,
    localparam int SELW = sel_width(NCH)
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic [SELW-1:0]         SEL,
    input  logic                    SEL_REQ,
    output logic                    SEL_ACK,
    output logic                    SEL_ERR,
    output logic [SELW-1:0]         CUR_SEL,
    input  logic [W-1:0]            DIN,
    input  logic                    DIN_VALID,
    input  logic                    DIN_LAST,
    output logic                    DIN_READY,
    output logic [NCH-1:0][W-1:0]   SEL_DOUT,
    output logic [NCH-1:0]          SEL_DOUT_VALID,
    output logic [NCH-1:0]          SEL_DOUT_LAST,
    input  logic [NCH-1:0]          SEL_DOUT_READY,
    input  logic [NCH-1:0][W-1:0]   SEL_DIN,
    input  logic [NCH-1:0]          SEL_DIN_VALID,
    input  logic [NCH-1:0]          SEL_DIN_LAST,
    output logic [NCH-1:0]          SEL_DIN_READY,
    output logic [W-1:0]            DOUT,
    output logic                    DOUT_VALID,
    output logic                    DOUT_LAST,
    input  logic                    DOUT_READY
);

    typedef `STREAM_SWITCHER_BEAT_T(W) beat_t;

    sw_state_t       state;
    logic [SELW-1:0] cur_sel;
    logic            sel_ack, sel_err;
    logic            dn_open, up_open;
    logic            dn_en, up_en, sel_ok, drained;
    logic            dn_s_ready, dn_m_valid, up_s_ready, up_m_valid;
    logic            up_in_valid, up_rdy;
    beat_t           dn_in, dn_out, up_in, up_out;

    assign sel_ok = int'(SEL) < NCH;
    assign drained = !dn_open && !up_open && !dn_m_valid && !up_m_valid;

    // While draining, only the remainder of an already-open packet may enter.
    assign dn_en = (state == IDLE) || ((state == DRAIN) && dn_open);
    assign up_en = (state == IDLE) || ((state == DRAIN) && up_open);

    assign dn_in.last  = DIN_LAST;
    assign dn_in.data  = DIN;
    assign DIN_READY   = dn_s_ready && dn_en;

    assign up_in_valid = SEL_DIN_VALID[cur_sel];
    assign up_in.last  = SEL_DIN_LAST[cur_sel];
    assign up_in.data  = SEL_DIN[cur_sel];
    assign up_rdy      = up_s_ready && up_en;

    stream_reg_slice #(.DATA_W(W + 1)) u_dn_slice (
        .clk     (CLK),
        .rst     (RST),
        .s_valid (DIN_VALID && dn_en),
        .s_ready (dn_s_ready),
        .s_data  (dn_in),
        .m_valid (dn_m_valid),
        .m_ready (SEL_DOUT_READY[cur_sel]),
        .m_data  (dn_out)
    );

    stream_reg_slice #(.DATA_W(W + 1)) u_up_slice (
        .clk     (CLK),
        .rst     (RST),
        .s_valid (up_in_valid && up_en),
        .s_ready (up_s_ready),
        .s_data  (up_in),
        .m_valid (up_m_valid),
        .m_ready (DOUT_READY),
        .m_data  (up_out)
    );

    always_comb begin
        SEL_DOUT       = '0;
        SEL_DOUT_VALID = '0;
        SEL_DOUT_LAST  = '0;
        SEL_DIN_READY  = '0;
        for (int i = 0; i < NCH; i++) begin
            SEL_DOUT[i] = dn_out.data;
            if (cur_sel == SELW'(i)) begin
                SEL_DOUT_VALID[i] = dn_m_valid;
                SEL_DOUT_LAST[i]  = dn_m_valid && dn_out.last;
                SEL_DIN_READY[i]  = up_rdy;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dn_open <= 1'b0;
            up_open <= 1'b0;
        end else begin
            if (DIN_VALID && DIN_READY) dn_open <= !DIN_LAST;
            if (up_in_valid && up_rdy)  up_open <= !up_in.last;
        end
    end

    // A request still held high while ACK/ERR is showing is the one just served.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state   <= IDLE;
            cur_sel <= '0;
            sel_ack <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            sel_ack <= 1'b0;
            sel_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (SEL_REQ && !sel_ack && !sel_err) begin
                        if (sel_ok) state <= DRAIN;
                        else        sel_err <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (!SEL_REQ)     state <= IDLE;
                    else if (drained) state <= SWITCH;
                end
                SWITCH: begin
                    state <= IDLE;
                    if (sel_ok) begin
                        cur_sel <= SEL;
                        sel_ack <= 1'b1;
                    end else begin
                        sel_err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign SEL_ACK    = sel_ack;
    assign SEL_ERR    = sel_err;
    assign CUR_SEL    = cur_sel;
    assign DOUT       = up_out.data;
    assign DOUT_VALID = up_m_valid;
    assign DOUT_LAST  = up_m_valid && up_out.last;

endmodule

// File: doc/stream_switcher.md
Name: stream_switcher

Overview:
- Parametrised, registered successor to the combinational channel switcher.
- Connects one upstream port to one of NCH channel ports in both directions:
  - downstream: DIN goes to SEL_DOUT[cur].
  - upstream: SEL_DIN[cur] goes to DOUT.
- Every stream carries valid/ready/last handshakes.
- The active channel changes only on a request handshake, and only at packet boundaries with the pipeline drained. This makes it safe to switch between multi-beat packets inside the datapath fabric.

Parameters:
- NCH, 8, number of channels (2..256, need not be a power of 2)
- W, 16, data width in bits
- SELW, $clog2(NCH), selector width (derived, not overridden)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- SEL  in  SELW  requested channel index
- SEL_REQ  in  1  switch request; held high until SEL_ACK or SEL_ERR
- SEL_ACK  out  1  one-cycle pulse: switch performed
- SEL_ERR  out  1  one-cycle pulse: SEL >= NCH, request rejected
- CUR_SEL  out  SELW  currently active channel
- DIN  in  W  upstream data toward channels
- DIN_VALID  in  1  DIN beat valid
- DIN_LAST  in  1  last beat of DIN packet
- DIN_READY  out  1  switcher accepts DIN beat
- SEL_DOUT  out  W x NCH  per-channel output data
- SEL_DOUT_VALID  out  NCH  per-channel output valid
- SEL_DOUT_LAST  out  NCH  per-channel output last
- SEL_DOUT_READY  in  NCH  per-channel output ready
- SEL_DIN  in  W x NCH  per-channel input data
- SEL_DIN_VALID  in  NCH  per-channel input valid
- SEL_DIN_LAST  in  NCH  per-channel input last
- SEL_DIN_READY  out  NCH  per-channel input ready
- DOUT  out  W  data from active channel
- DOUT_VALID  out  1  DOUT beat valid
- DOUT_LAST  out  1  last beat of DOUT packet
- DOUT_READY  in  1  consumer accepts DOUT

Behaviour:
- Clocking and reset:
  - One clock CLK. Reset is asynchronous and active-high on RST.
  - Reset values: CUR_SEL=0, SEL_ACK=0, SEL_ERR=0, all VALID/LAST outputs 0, all data outputs 0, both open flags 0, FSM in IDLE.
- Handshake:
  - A beat transfers when valid && ready on the same rising edge.
  - Once valid is asserted, data and last hold until the transfer.
- Each direction is a one-entry register slice:
  - Latency 1 cycle.
  - Full throughput: slice ready = !q_valid || downstream ready.
- Downstream direction:
  - DIN_READY = ready of the slice routed to CUR_SEL.
  - Only SEL_DOUT_VALID[CUR_SEL] may be 1. All other SEL_DOUT_VALID/LAST are 0.
  - All SEL_DOUT data lanes carry the slice data (broadcast).
- Upstream direction:
  - Only SEL_DIN_READY[CUR_SEL] may be 1.
  - Valid/last/data of inactive channels are ignored.
- Open-packet flags dn_open and up_open, one per direction, on input-side acceptance:
  - set when a beat with last=0 is accepted;
  - clear when a beat with last=1 is accepted;
  - a single beat with last=1 never sets the flag.
- FSM states: IDLE, DRAIN, SWITCH.
  - IDLE: if SEL_REQ and SEL >= NCH, pulse SEL_ERR next cycle and stay in IDLE. If SEL_REQ and SEL < NCH, go to DRAIN.
  - DRAIN:
    - Both input readies are forced to 0, so no new beats are accepted.
    - Stay until both open flags are 0 and both slices are empty.
    - Then go to SWITCH.
    - If an open flag is 1, the port stays unblocked until the last beat is accepted. Only the first beat of a new packet is stalled.
  - SWITCH: latch CUR_SEL <= SEL, pulse SEL_ACK for one cycle, return to IDLE.
- Request rules:
  - SEL is sampled in SWITCH.
  - Changing SEL while SEL_REQ is held is legal; the latest value wins.
  - Dropping SEL_REQ in DRAIN returns to IDLE with no ACK.
  - A request for the channel already in CUR_SEL still drains and ACKs.
- Boundary cases:
  - Last beat accepted on the same edge that SEL_REQ rises: the flag clears that edge, and the ACK follows after drain plus 1.
  - Slice full with downstream ready=0 stalls DRAIN indefinitely. There is no timeout.
  - RST mid-packet: in-flight beats are discarded, flags clear, CUR_SEL returns to 0.

Decomposition:
- Package stream_switcher_pkg:
  - typedef beat_t: packed struct {last, data[W-1:0]}, parametrised via macro as the FPU types are;
  - FSM state enum;
  - constant SELW function.
- One sub-module, stream_reg_slice (W+1 bits, valid/ready), instantiated twice.

Test Plan:
1. Reset with RST=1 for 3 cycles -> CUR_SEL=0, all valids 0, DIN_READY=1 after release.
2. CUR_SEL=0, send 4-beat packet 0x1111..0x4444 on DIN, all SEL_DOUT_READY=1 -> SEL_DOUT_VALID=8'b00000001, beats appear 1 cycle later in order, last on 0x4444; SEL_DOUT_VALID[7:1] never 1.
3. Request SEL=5 after beat 2 of a 4-beat DIN packet -> beats 3 and 4 are still accepted, SEL_ACK arrives at drain plus 1, CUR_SEL=5; SEL_DIN[5]=0xABCD with last=1 appears on DOUT 1 cycle after acceptance.
4. NCH=6, request SEL=7 -> SEL_ERR pulses for 1 cycle, CUR_SEL unchanged, no ACK.
5. Hold DOUT_READY=0 with the slice full, then request a switch -> no ACK; raise DOUT_READY -> ACK 2 cycles later.
6. Assert RST mid-packet at beat 2 of 4 -> all valids 0 immediately (asynchronous); after release, a new request is ACKed without waiting for the stale last beat.
